// File: rtl/sp_unit_multi_cmd.sv
// In-order command tracker: queues issued channel IDs, presents the oldest to
// writeback, and keeps per-channel outstanding counts for busy/done status.
module sp_unit_multi_cmd #(
  parameter int NUM_CMDS = 4,
  parameter int DEPTH    = 4,
  localparam int CMD_W   = $clog2(NUM_CMDS),
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_new_request,
  input  logic                issue_cmd,
  input  logic [CMD_W-1:0]    issue_cmd_id,
  output logic                issue_ready,
  input  logic                wb_ack,
  output logic                wb_valid,
  output logic [CMD_W-1:0]    wb_cmd_id,
  output logic [NUM_CMDS-1:0] cmd_busy,
  output logic [NUM_CMDS-1:0] cmd_done,
  output logic [OCC_W-1:0]    occupancy,
  output logic                err_ack_empty,
  output logic                err_bad_id
);

  localparam int PTR_W = $clog2(DEPTH);
  // One extra bit so the range check never degenerates when NUM_CMDS is a power of two.
  localparam logic [CMD_W:0]   ID_LIMIT = (CMD_W + 1)'(NUM_CMDS);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [NUM_CMDS-1:0][OCC_W-1:0] cnt_q, cnt_d;
  logic err_ack_empty_q, err_ack_empty_d;
  logic err_bad_id_q, err_bad_id_d;

  logic full, empty, offer, id_ok, acc, ret;
  logic [CMD_W-1:0] head_id;

  assign full    = (occ_q == OCC_FULL);
  assign empty   = (occ_q == '0);
  assign offer   = issue_new_request & ~full & issue_cmd;
  assign id_ok   = ({1'b0, issue_cmd_id} < ID_LIMIT);
  assign acc     = offer & id_ok;
  assign ret     = wb_ack & ~empty;
  assign head_id = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d        = wr_ptr_q + PTR_W'(acc);
    rd_ptr_d        = rd_ptr_q + PTR_W'(ret);
    occ_d           = occ_q + OCC_W'(acc) - OCC_W'(ret);
    err_ack_empty_d = wb_ack & empty;
    err_bad_id_d    = offer & ~id_ok;
  end

  // Same-channel accept and retire cancel, so the counter is left unchanged.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_CMDS; i++) begin
      cnt_d[i] = cnt_q[i]
               + OCC_W'(acc && (issue_cmd_id == CMD_W'(i)))
               - OCC_W'(ret && (head_id == CMD_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      cnt_q           <= '0;
      err_ack_empty_q <= 1'b0;
      err_bad_id_q    <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      cnt_q           <= cnt_d;
      err_ack_empty_q <= err_ack_empty_d;
      err_bad_id_q    <= err_bad_id_d;
    end
  end

  // Payload storage needs no reset; stale entries are masked by empty.
  always_ff @(posedge clk) begin
    if (acc) begin
      mem_q[wr_ptr_q] <= issue_cmd_id;
    end
  end

  assign issue_ready   = ~full;
  assign wb_valid      = ~empty;
  assign wb_cmd_id     = empty ? '0 : head_id;
  assign occupancy     = occ_q;
  assign err_ack_empty = err_ack_empty_q;
  assign err_bad_id    = err_bad_id_q;

  for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_chan
    assign cmd_busy[gi] = (cnt_q[gi] != '0);
    assign cmd_done[gi] = ~empty & (head_id == CMD_W'(gi));
  end

`ifndef SYNTHESIS
  int cnt_sum;
  always_comb begin
    cnt_sum = 0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      cnt_sum += int'(cnt_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt_sum == int'(occ_q))
        else $error("occupancy %0d disagrees with channel count sum %0d", occ_q, cnt_sum);
      assert (occ_q <= OCC_FULL)
        else $error("occupancy %0d above depth", occ_q);
    end
  end
`endif

endmodule

// File: tb/tb_sp_unit_multi_cmd.sv
// Directed bench for sp_unit_multi_cmd: a 4-channel instance for the main
// scenarios plus a 3-channel instance for the out-of-range channel ID case.
module tb_sp_unit_multi_cmd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0, cmd = 1'b0, ack = 1'b0;
  logic [1:0] id  = '0;
  logic       ready, valid, err_ae, err_bid;
  logic [1:0] head;
  logic [3:0] busy, done;
  logic [2:0] occ;

  logic       b_req = 1'b0, b_ack = 1'b0;
  logic [1:0] b_id  = '0;
  logic       b_ready, b_valid, b_err_ae, b_err_bid;
  logic [1:0] b_head;
  logic [2:0] b_busy, b_done;
  logic [2:0] b_occ;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sp_unit_multi_cmd #(.NUM_CMDS(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .issue_new_request(req), .issue_cmd(cmd), .issue_cmd_id(id),
    .issue_ready(ready), .wb_ack(ack), .wb_valid(valid), .wb_cmd_id(head),
    .cmd_busy(busy), .cmd_done(done), .occupancy(occ),
    .err_ack_empty(err_ae), .err_bad_id(err_bid)
  );

  sp_unit_multi_cmd #(.NUM_CMDS(3), .DEPTH(4)) dut3 (
    .clk(clk), .rst(rst),
    .issue_new_request(b_req), .issue_cmd(b_req), .issue_cmd_id(b_id),
    .issue_ready(b_ready), .wb_ack(b_ack), .wb_valid(b_valid), .wb_cmd_id(b_head),
    .cmd_busy(b_busy), .cmd_done(b_done), .occupancy(b_occ),
    .err_ack_empty(b_err_ae), .err_bad_id(b_err_bid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // One clock with the given request/ack; sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic [1:0] i, input logic a);
    req = r; cmd = r; id = i; ack = a;
    @(posedge clk);
    #1;
    req = 1'b0; cmd = 1'b0; id = '0; ack = 1'b0;
  endtask

  int         q[$];
  logic [3:0] eb;
  logic       m_acc, m_ret, do_iss, do_ack;
  logic [1:0] m_id;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_head", head, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_occ", occ, 0);

    // T1 single command
    cyc(1, 2, 0);
    chk("t1_busy", busy, 4'b0100);
    chk("t1_done", done, 4'b0100);
    chk("t1_head", head, 2);
    chk("t1_occ", occ, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("t1_busy_clr", busy, 0);
    chk("t1_done_clr", done, 0);
    chk("t1_valid_clr", valid, 0);

    // issue_cmd=0 offers are ignored
    req = 1'b1; cmd = 1'b0; id = 2'd1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("nocmd_occ", occ, 0);

    // T2 fill to full, reject extra, drain in order
    cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 3, 0);
    chk("t2_occ_full", occ, 4);
    chk("t2_ready_lo", ready, 0);
    chk("t2_busy", busy, 4'b1011);
    cyc(1, 0, 0);
    chk("t2_reject_occ", occ, 4);
    chk("t2_head0", head, 0);
    cyc(0, 0, 1);
    chk("t2_head1", head, 1);
    chk("t2_busy_a", busy, 4'b1010);
    chk("t2_ready_back", ready, 1);
    cyc(0, 0, 1);
    chk("t2_head1b", head, 1);
    chk("t2_busy_b", busy, 4'b1010);
    cyc(0, 0, 1);
    chk("t2_head3", head, 3);
    chk("t2_busy_c", busy, 4'b1000);
    cyc(0, 0, 1);
    chk("t2_empty", valid, 0);
    chk("t2_busy_d", busy, 0);

    // T3 simultaneous accept and retire
    cyc(1, 0, 0); cyc(1, 1, 0);
    cyc(1, 0, 1);
    chk("t3_occ", occ, 2);
    chk("t3_busy", busy, 4'b0011);
    chk("t3_head", head, 1);
    cyc(1, 2, 1);
    chk("t3_diff_occ", occ, 2);
    chk("t3_diff_busy", busy, 4'b0101);
    chk("t3_diff_head", head, 0);
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk("t3_drained", occ, 0);

    // T4 full plus ack: offer refused, ready returns next cycle
    cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 3, 0); cyc(1, 0, 0);
    cyc(1, 1, 1);
    chk("t4_occ", occ, 3);
    chk("t4_ready", ready, 1);
    chk("t4_head", head, 2);
    cyc(1, 1, 0);
    chk("t4_refill", occ, 4);
    chk("t4_busy", busy, 4'b1111);
    cyc(0, 0, 1); chk("t4_h3", head, 3);
    cyc(0, 0, 1); chk("t4_h0", head, 0);
    cyc(0, 0, 1); chk("t4_h1", head, 1);
    cyc(0, 0, 1); chk("t4_empty", valid, 0);

    // T5 ack while empty, then ack-while-empty with an accept
    cyc(0, 0, 1);
    chk("t5_err_ae", err_ae, 1);
    chk("t5_occ", occ, 0);
    cyc(0, 0, 0);
    chk("t5_err_ae_pulse", err_ae, 0);
    cyc(1, 3, 1);
    chk("t5_ae_acc_err", err_ae, 1);
    chk("t5_ae_acc_occ", occ, 1);
    chk("t5_ae_acc_head", head, 3);
    cyc(0, 0, 1);
    chk("t5_ae_acc_drain", occ, 0);

    // T5 bad channel ID on the 3-channel instance
    b_req = 1'b1; b_id = 2'd3;
    @(posedge clk); #1;
    b_req = 1'b0; b_id = '0;
    chk("t5_bad_err", b_err_bid, 1);
    chk("t5_bad_busy", b_busy, 0);
    chk("t5_bad_occ", b_occ, 0);
    @(posedge clk); #1;
    chk("t5_bad_pulse", b_err_bid, 0);
    b_req = 1'b1; b_id = 2'd2;
    @(posedge clk); #1;
    b_req = 1'b0; b_id = '0;
    chk("t5_good_busy", b_busy, 3'b100);
    chk("t5_good_err", b_err_bid, 0);
    chk("t5_good_head", b_head, 2);

    // T6 reset mid-operation
    cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 2, 0);
    chk("t6_occ3", occ, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_occ", occ, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_ready", ready, 1);
    cyc(1, 1, 0);
    chk("t6_busy1", busy, 4'b0010);
    chk("t6_done1", done, 4'b0010);
    chk("t6_head1", head, 1);
    cyc(0, 0, 1);
    chk("t6_empty", valid, 0);

    // Pointer wrap-around against a queue model
    q.delete();
    for (int i = 0; i < 30; i++) begin
      do_iss = (i % 4) != 3;
      do_ack = (i % 3) != 0;
      m_id   = 2'((i * 3) % 4);
      m_acc  = do_iss && (q.size() < 4);
      m_ret  = do_ack && (q.size() > 0);
      if (m_ret) void'(q.pop_front());
      if (m_acc) q.push_back(int'(m_id));
      cyc(do_iss, m_id, do_ack);
      eb = '0;
      foreach (q[k]) eb[q[k]] = 1'b1;
      chk($sformatf("wrap%0d_occ", i), occ, q.size());
      chk($sformatf("wrap%0d_head", i), head, (q.size() > 0) ? q[0] : 0);
      chk($sformatf("wrap%0d_busy", i), busy, eb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
